// File: rtl/lsu_pkg.sv
// Shared types, op encodings and decode helpers for the LSU memory sequencer.
package lsu_pkg;

    localparam int LOAD_OP_WIDTH  = 3;
    localparam int STORE_OP_WIDTH = 2;

    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LB  = 3'd0;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LH  = 3'd1;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LW  = 3'd2;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LBU = 3'd4;
    localparam logic [LOAD_OP_WIDTH-1:0] LOAD_OP_LHU = 3'd5;

    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 2'd0;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 2'd1;
    localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_NONE
    } size_e;

    function automatic size_e op_size(input logic                      we,
                                      input logic [LOAD_OP_WIDTH-1:0]  lop,
                                      input logic [STORE_OP_WIDTH-1:0] sop);
        size_e sz;
        sz = SZ_NONE;
        if (we) begin
            case (sop)
                STORE_OP_SB: sz = SZ_BYTE;
                STORE_OP_SH: sz = SZ_HALF;
                STORE_OP_SW: sz = SZ_WORD;
                default:     sz = SZ_NONE;
            endcase
        end else begin
            case (lop)
                LOAD_OP_LB, LOAD_OP_LBU: sz = SZ_BYTE;
                LOAD_OP_LH, LOAD_OP_LHU: sz = SZ_HALF;
                LOAD_OP_LW:              sz = SZ_WORD;
                default:                 sz = SZ_NONE;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_illegal(input logic                      we,
                                        input logic [LOAD_OP_WIDTH-1:0]  lop,
                                        input logic [STORE_OP_WIDTH-1:0] sop);
        return op_size(we, lop, sop) == SZ_NONE;
    endfunction

    function automatic logic is_misaligned(input logic                      we,
                                           input logic [LOAD_OP_WIDTH-1:0]  lop,
                                           input logic [STORE_OP_WIDTH-1:0] sop,
                                           input logic [1:0]                off);
        case (op_size(we, lop, sop))
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Picks the addressed byte/half out of the bus word and sign- or zero-extends it.
    function automatic logic [31:0] load_extract(input logic [LOAD_OP_WIDTH-1:0] lop,
                                                 input logic [1:0]               off,
                                                 input logic [31:0]              data);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{off, 3'b000} +: 8];
        h = data[{off[1], 4'b0000} +: 16];
        case (lop)
            LOAD_OP_LB:  return {{24{b[7]}}, b};
            LOAD_OP_LBU: return {24'h0, b};
            LOAD_OP_LH:  return {{16{h[15]}}, h};
            LOAD_OP_LHU: return {16'h0, h};
            default:     return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Store lane steering: byte strobes and replicated write data from op and address offset.
module lsu_store_align
    import lsu_pkg::*;
(
    input  logic [STORE_OP_WIDTH-1:0] store_op,
    input  logic [1:0]                addr_lo,
    input  logic [31:0]               wdata,
    output logic [3:0]                wstrb,
    output logic [31:0]               wdata_rep
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        wstrb     = 4'b0000;
        wdata_rep = 32'h0;
        case (store_op)
            STORE_OP_SB: begin
                wstrb     = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            STORE_OP_SH: begin
                wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
            end
            STORE_OP_SW: begin
                wstrb     = 4'b1111;
                wdata_rep = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// One-outstanding load/store sequencer between the core datapath and the memory bus.
// Optional bus timeout fault is enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_sequencer
    import lsu_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [LOAD_OP_WIDTH-1:0]  load_op,
    input  logic [STORE_OP_WIDTH-1:0] store_op,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_misalign,
    output logic                      rsp_err,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    output logic [3:0]                mem_wstrb,
    input  logic [31:0]               mem_rdata
);

    state_e                   state_q, state_d;
    logic                     we_q, we_d;
    logic [LOAD_OP_WIDTH-1:0] lop_q, lop_d;
    logic [31:0]              addr_q, addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [3:0]               wstrb_q, wstrb_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     misalign_q, misalign_d;
    logic                     err_q, err_d;

    logic [3:0]               st_wstrb;
    logic [31:0]              st_wdata;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    lsu_store_align u_store_align (
        .store_op  (store_op),
        .addr_lo   (req_addr[1:0]),
        .wdata     (req_wdata),
        .wstrb     (st_wstrb),
        .wdata_rep (st_wdata)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        lop_d      = lop_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        err_d      = err_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    lop_d      = load_op;
                    addr_d     = req_addr;
                    wdata_d    = req_we ? st_wdata : 32'h0;
                    wstrb_d    = req_we ? st_wstrb : 4'b0000;
                    rdata_d    = 32'h0;
                    misalign_d = 1'b0;
                    err_d      = 1'b0;
`ifdef LSU_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                    // Illegal encodings report as access faults; no bus cycle either way.
                    if (is_illegal(req_we, load_op, store_op)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (is_misaligned(req_we, load_op, store_op, req_addr[1:0])) begin
                        misalign_d = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ready) begin
                    rdata_d = we_q ? 32'h0 : load_extract(lop_q, addr_q[1:0], mem_rdata);
                    state_d = ST_RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            lop_q      <= '0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            lop_q      <= lop_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            err_q      <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign mem_valid    = (state_q == ST_BUS);
    assign rsp_valid    = (state_q == ST_RESP);
    assign rsp_rdata    = rsp_valid ? rdata_q : 32'h0;
    assign rsp_misalign = rsp_valid & misalign_q;
    assign rsp_err      = rsp_valid & err_q;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Randomized self-checking bench for lsu_mem_sequencer against a behavioural LSU model.
module tb_lsu_mem_sequencer;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  load_op;
    logic [1:0]  store_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    lsu_mem_sequencer dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .load_op      (load_op),
        .store_op     (store_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_misalign (rsp_misalign),
        .rsp_err      (rsp_err),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: access size in bytes, 0 for an undefined encoding.
    function automatic int m_size(input logic we, input logic [2:0] lop, input logic [1:0] sop);
        if (we) return (sop == 2'd0) ? 1 : (sop == 2'd1) ? 2 : (sop == 2'd2) ? 4 : 0;
        case (lop)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] lop, input logic [31:0] addr,
                                           input logic [31:0] data);
        int          sz;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        sz   = m_size(1'b0, lop, 2'd0);
        off  = int'(addr % 4) & (4 - sz);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
        v    = (data >> (8 * off)) & mask;
        if ((lop == 3'd0 || lop == 3'd1) && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] m_strb(input int sz, input logic [31:0] addr);
        int off;
        off = int'(addr % 4) & (4 - sz);
        return 4'(((1 << sz) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] wd);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'(wd >> (8 * (j % sz)));
        return r;
    endfunction

    task automatic run_op(input logic we, input logic [2:0] lop, input logic [1:0] sop,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int waits, input string tag);
        int          sz;
        logic        exc;
        logic [31:0] exp_rdata;
        sz  = m_size(we, lop, sop);
        exc = (sz == 0) || ((addr % sz) != 0);
        exp_rdata = (we || exc) ? 32'h0 : m_load(lop, addr, rd);

        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: ready=%b rsp_valid=%b mem_valid=%b, want 1/0/0",
                     tag, req_ready, rsp_valid, mem_valid);
        end
        req_valid = 1'b1; req_we = we; load_op = lop; store_op = sop;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = $urandom(); req_addr = $urandom(); req_wdata = $urandom();

        if (!exc) begin
            for (int c = 0; c <= waits; c++) begin
                checks++;
                if (mem_valid !== 1'b1 || rsp_valid !== 1'b0 || mem_addr !== (addr & 32'hFFFF_FFFC) ||
                    mem_wstrb !== (we ? m_strb(sz, addr) : 4'b0000) ||
                    (we && mem_wdata !== m_wdata(sz, wd))) begin
                    errors++;
                    $display("FAIL %s bus c%0d: valid=%b rsp=%b addr=%h strb=%b wdata=%h, want 1/0/%h/%b/%h",
                             tag, c, mem_valid, rsp_valid, mem_addr, mem_wstrb, mem_wdata,
                             addr & 32'hFFFF_FFFC, we ? m_strb(sz, addr) : 4'b0000, m_wdata(sz, wd));
                end
                mem_ready = (c == waits);
                mem_rdata = (c == waits) ? rd : $urandom();
                @(posedge clk);
                @(negedge clk);
                mem_ready = 1'b0;
                mem_rdata = $urandom();
            end
        end
        checks++;
        if (rsp_valid !== 1'b1 || mem_valid !== 1'b0 || rsp_rdata !== exp_rdata ||
            rsp_misalign !== (exc && sz != 0) || rsp_err !== (sz == 0)) begin
            errors++;
            $display("FAIL %s rsp: valid=%b mem_valid=%b rdata=%h mis=%b err=%b, want 1/0/%h/%b/%b",
                     tag, rsp_valid, mem_valid, rsp_rdata, rsp_misalign, rsp_err,
                     exp_rdata, exc && sz != 0, sz == 0);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; load_op = 3'd0; store_op = 2'd0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_misalign !== 1'b0 || rsp_err !== 1'b0 ||
            mem_valid !== 1'b0 || rsp_rdata !== 32'h0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || mem_wstrb !== 4'b0000) begin
            errors++;
            $display("FAIL reset: ready=%b rv=%b mis=%b err=%b mv=%b rd=%h ma=%h wd=%h st=%b, want 1,0s",
                     req_ready, rsp_valid, rsp_misalign, rsp_err, mem_valid, rsp_rdata,
                     mem_addr, mem_wdata, mem_wstrb);
        end
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        run_op(1'b0, 3'd2, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 3, "lw_0x100");
        run_op(1'b0, 3'd0, 2'd0, 32'h103, 32'h0, 32'h80FFFFFF, 0, "lb_0x103");
        checks++;
        if (rsp_rdata !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_sign: rdata=%h want FFFFFF80", rsp_rdata);
        end
        run_op(1'b0, 3'd4, 2'd0, 32'h103, 32'h0, 32'h80FFFFFF, 1, "lbu_0x103");
        run_op(1'b1, 3'd0, 2'd1, 32'h202, 32'h1234ABCD, 32'h0, 2, "sh_0x202");
        run_op(1'b1, 3'd0, 2'd0, 32'h301, 32'h000000A5, 32'h0, 0, "sb_0x301");
        run_op(1'b1, 3'd0, 2'd2, 32'h400, 32'hCAFEF00D, 32'h0, 0, "sw_0x400");
        run_op(1'b0, 3'd1, 2'd0, 32'h502, 32'h0, 32'h8001_7FFF, 0, "lh_0x502");
        run_op(1'b0, 3'd5, 2'd0, 32'h500, 32'h0, 32'h8001_F00F, 0, "lhu_0x500");
    endtask

    task automatic test_exceptions();
        run_op(1'b0, 3'd2, 2'd0, 32'h101, 32'h0, 32'h0, 0, "lw_misalign");
        run_op(1'b0, 3'd5, 2'd0, 32'h103, 32'h0, 32'h0, 0, "lhu_misalign");
        run_op(1'b1, 3'd0, 2'd1, 32'h201, 32'hFFFF, 32'h0, 0, "sh_misalign");
        run_op(1'b1, 3'd0, 2'd2, 32'h202, 32'hFFFF, 32'h0, 0, "sw_misalign");
        run_op(1'b0, 3'd3, 2'd0, 32'h100, 32'h0, 32'h0, 0, "ld_illegal");
        run_op(1'b1, 3'd0, 2'd3, 32'h100, 32'h1, 32'h0, 0, "st_illegal");
    endtask

    task automatic test_back_to_back();
        logic [2:0] lops [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        for (int i = 0; i < 60; i++) begin
            logic       we;
            logic [2:0] lop;
            logic [1:0] sop;
            we  = $urandom_range(0, 1);
            lop = ($urandom_range(0, 9) == 0) ? 3'($urandom()) : lops[$urandom_range(0, 4)];
            sop = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_op(we, lop, sop, 32'h1000 + 32'($urandom_range(0, 255)), $urandom(), $urandom(),
                   $urandom_range(0, 4), "random");
        end
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; load_op = 3'd2; req_addr = 32'h600;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_bus: mem_valid=%b ready=%b rsp_valid=%b, want 0/1/0",
                     mem_valid, req_ready, rsp_valid);
        end
        @(negedge clk);
        resetn = 1'b1;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            checks++;
            if (rsp_valid !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rst_release c%0d: rsp_valid=%b mem_valid=%b ready=%b, want 0/0/1",
                         c, rsp_valid, mem_valid, req_ready);
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; load_op = 3'd2; req_addr = 32'h700;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 255; c++) begin
            if (mem_valid !== 1'b1 || rsp_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 ||
            mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout: bad_bus_cycles=%0d rv=%b err=%b rd=%h mv=%b, want 0/1/1/0/0",
                     bad, rsp_valid, rsp_err, rsp_rdata, mem_valid);
        end
        run_op(1'b0, 3'd2, 2'd0, 32'h704, 32'h0, 32'h0BAD_F00D, 254, "ready_at_limit");
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_exceptions();
        test_back_to_back();
        test_reset_mid_bus();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
